totient_seq_gen: RTL

//   Upstream stage of the Euler-totient display path. It computes phi(n) arithmetically for n = 1..N_MAX.
//   It does this by counting k in 1..n with gcd(k,n)==1, using subtractive Euclid.

---
 rtl/totient_seq_gen.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/totient_seq_gen.sv
// totient_seq_gen: computes Euler's phi(n) for n = 1..N_MAX by counting the k in 1..n
// that are coprime to n (subtractive Euclid). Each result is presented on a
// valid/ready port. While run stays high, the sequence repeats from n = 1.
module totient_seq_gen #(
  parameter int unsigned N_MAX = 16,
  parameter int unsigned NW    = 5
) (
  input  logic          clk_0,
  input  logic          R,
  input  logic          run,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [NW-1:0] n_out,
  output logic [NW-1:0] phi_out,
  output logic          seq_start,
  output logic          seq_end,
  output logic          busy
);

  localparam logic [NW-1:0] One  = NW'(1);
  localparam logic [NW-1:0] NMax = NW'(N_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StGcd,
    StTally,
    StPresent
  } state_e;

  state_e state_q, state_d;

  // Sequence position and per-n accumulator
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] k_q, k_d;
  logic [NW-1:0] cnt_q, cnt_d;

  // Euclid operands
  logic [NW-1:0] a_q, a_d;
  logic [NW-1:0] b_q, b_d;

  // Presented result
  logic          out_valid_q, out_valid_d;
  logic [NW-1:0] n_out_q, n_out_d;
  logic [NW-1:0] phi_out_q, phi_out_d;
  logic          seq_start_q, seq_start_d;
  logic          seq_end_q, seq_end_d;
  logic          busy_q, busy_d;

  // Count after the current gcd is tallied; a_q holds gcd(k, n) in StTally.
  logic [NW-1:0] cnt_tally;
  assign cnt_tally = (a_q == One) ? (cnt_q + One) : cnt_q;

  // Next-state and datapath decode
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    n_out_d     = n_out_q;
    phi_out_d   = phi_out_q;
    seq_start_d = seq_start_q;
    seq_end_d   = seq_end_q;

    unique case (state_q)
      StIdle: begin
        if (run) begin
          n_d     = One;
          k_d     = One;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end

      StLoad: begin
        a_d     = n_q;
        b_d     = k_q;
        state_d = StGcd;
      end

      StGcd: begin
        // One subtraction per cycle; the larger operand shrinks, so neither reaches zero.
        if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else if (b_q > a_q) begin
          b_d = b_q - a_q;
        end else begin
          state_d = StTally;
        end
      end

      StTally: begin
        cnt_d = cnt_tally;
        if (k_q == n_q) begin
          n_out_d     = n_q;
          phi_out_d   = cnt_tally;
          out_valid_d = 1'b1;
          seq_start_d = (n_q == One);
          seq_end_d   = (n_q == NMax);
          state_d     = StPresent;
        end else begin
          k_d     = k_q + One;
          state_d = StLoad;
        end
      end

      StPresent: begin
        // out_valid_q is always set here, so out_ready alone marks the handshake.
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          k_d         = One;
          if (n_q < NMax) begin
            n_d     = n_q + One;
            state_d = StLoad;
          end else if (run) begin
            n_d     = One;
            state_d = StLoad;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // busy is registered from the next state so it tracks state_q exactly.
  always_comb begin
    busy_d = (state_d != StIdle);
  end

  // FSM state register
  always_ff @(posedge clk_0 or negedge R) begin
    if (!R) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequence counters and Euclid operands
  always_ff @(posedge clk_0 or negedge R) begin
    if (!R) begin
      n_q   <= One;
      k_q   <= One;
      cnt_q <= '0;
      a_q   <= One;
      b_q   <= One;
    end else begin
      n_q   <= n_d;
      k_q   <= k_d;
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  // Presented result and status flags
  always_ff @(posedge clk_0 or negedge R) begin
    if (!R) begin
      out_valid_q <= 1'b0;
      n_out_q     <= '0;
      phi_out_q   <= '0;
      seq_start_q <= 1'b0;
      seq_end_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      n_out_q     <= n_out_d;
      phi_out_q   <= phi_out_d;
      seq_start_q <= seq_start_d;
      seq_end_q   <= seq_end_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign n_out     = n_out_q;
  assign phi_out   = phi_out_q;
  assign seq_start = seq_start_q;
  assign seq_end   = seq_end_q;
  assign busy      = busy_q;

  // Euclid operands stay nonzero, so the reduction always terminates.
  a_gcd_nonzero: assert property (@(posedge clk_0) disable iff (!R)
    (state_q == StGcd) |-> ((a_q != '0) && (b_q != '0)));

  // A presented result is held unchanged until it is accepted.
  a_hold_until_ready: assert property (@(posedge clk_0) disable iff (!R)
    (out_valid_q && !out_ready) |=>
      (out_valid_q && $stable(n_out_q) && $stable(phi_out_q)));

endmodule
